// File: rtl/awgn_pkg.sv
// awgn_pkg: shared widths, FSM state encoding and the input triple payload
// for the Box-Muller output stage.
//   F_W    : width of the UQ3.14 radius f
//   G_W    : width of the Q1.15 cos/sin terms g0/g1
//   OUT_W  : width of the Q4.12 output sample
//   PROD_W : width of the signed 18x16 product (Q4.29)
//   SHIFT  : right shift taking Q4.29 down to Q4.12
package awgn_pkg;

  localparam int unsigned F_W    = 17;
  localparam int unsigned G_W    = 16;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned PROD_W = 34;
  localparam int unsigned SHIFT  = 17;

  // f zero-extended by one bit so it can enter a signed multiply
  localparam int unsigned FX_W   = F_W + 1;

  // Output-stage FSM states
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    CALC  = 2'd1,
    SEND0 = 2'd2,
    SEND1 = 2'd3
  } bm_state_e;

  // Registered upstream triple; g0/g1 are Q1.15 two's complement
  typedef struct packed {
    logic [F_W-1:0] f;
    logic [G_W-1:0] g0;
    logic [G_W-1:0] g1;
  } bm_triple_t;

endpackage

// File: rtl/bm_output_stage_if.sv
// bm_output_stage_if: upstream triple handshake plus downstream sample
// handshake of the Box-Muller output stage.
//   in_valid/in_ready  : triple handshake (f, g0, g1)
//   out_valid/out_ready: sample handshake (out_data, out_idx)
// Modports:
//   master : the environment (drives the triple, consumes samples)
//   slave  : the output stage
interface bm_output_stage_if;
  import awgn_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [F_W-1:0]   f;
  logic [G_W-1:0]   g0;
  logic [G_W-1:0]   g1;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_idx;

  modport master (
    output in_valid, f, g0, g1, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, f, g0, g1, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/bm_scale_mul.sv
// bm_scale_mul: scales a Q1.15 trig term by the UQ3.14 radius and reduces
// the Q4.29 product to a Q4.12 sample. Purely combinational.
// Build option: define AWGN_ROUND_EN for round-half-up, otherwise floor.
// Ports:
//   f   : in,  F_W unsigned UQ3.14 radius
//   g   : in,  G_W signed Q1.15 cos or sin
//   x_c : out, OUT_W signed Q4.12 product (combinational)
module bm_scale_mul
  import awgn_pkg::*;
(
  input  logic [F_W-1:0]          f,
  input  logic signed [G_W-1:0]   g,
  output logic signed [OUT_W-1:0] x_c
);

  logic signed [FX_W-1:0]   f_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_r;

  // Radius is unsigned: a zero sign bit keeps it positive in the signed product
  assign f_s  = {1'b0, f};
  assign prod = PROD_W'(f_s) * PROD_W'(g);

`ifdef AWGN_ROUND_EN
  // Half an output LSB added before the shift gives round-half-up
  assign prod_r = prod + $signed(PROD_W'(2 ** (SHIFT - 1)));
`else
  assign prod_r = prod;
`endif

  // Every radius/trig combination lands inside Q4.12, so no saturation
  assign x_c = OUT_W'(prod_r >>> SHIFT);

endmodule

// File: rtl/bm_output_stage.sv
// bm_output_stage: accepts one (f, g0, g1) triple, computes x0 = f*g0 and
// x1 = f*g1 in Q4.12, and emits them as two samples (idx 0 then idx 1).
// Build option: AWGN_ROUND_EN selects rounding in bm_scale_mul.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bm_output_stage_if.slave
//         in_valid/in_ready/f/g0/g1          upstream triple
//         out_valid/out_ready/out_data/out_idx downstream samples
// in_ready is combinational: in SEND1 it follows out_ready so a new triple
// can be taken in the same cycle the last sample leaves.
module bm_output_stage
  import awgn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bm_output_stage_if.slave   bus
);

  bm_state_e              state_q, state_d;
  bm_triple_t             trip_q,  trip_d;
  logic [OUT_W-1:0]       x1_q,    x1_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_idx_q,   out_idx_d;
  logic                   in_ready_c;
  logic signed [OUT_W-1:0] x0_c;
  logic signed [OUT_W-1:0] x1_c;
  bm_triple_t             in_trip_c;

  assign in_trip_c = '{f: bus.f, g0: bus.g0, g1: bus.g1};

  // Two scalers, one per trig term, fed from the registered triple
  bm_scale_mul u_mul_x0 (
    .f   (trip_q.f),
    .g   ($signed(trip_q.g0)),
    .x_c (x0_c)
  );

  bm_scale_mul u_mul_x1 (
    .f   (trip_q.f),
    .g   ($signed(trip_q.g1)),
    .x_c (x1_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trip_q      <= '0;
      x1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 1'b0;
    end else begin
      trip_q      <= trip_d;
      x1_q        <= x1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Next-state, next-output and handshake decode
  always_comb begin
    state_d     = state_q;
    trip_d      = trip_q;
    x1_d        = x1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    in_ready_c  = 1'b0;

    unique case (state_q)
      EMPTY: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          trip_d  = in_trip_c;
          state_d = CALC;
        end
      end

      CALC: begin
        // out_data doubles as the x0 register; x1 waits in x1_q
        out_data_d  = OUT_W'(x0_c);
        x1_d        = OUT_W'(x1_c);
        out_valid_d = 1'b1;
        out_idx_d   = 1'b0;
        state_d     = SEND0;
      end

      SEND0: begin
        if (bus.out_ready) begin
          out_data_d = x1_q;
          out_idx_d  = 1'b1;
          state_d    = SEND1;
        end
      end

      SEND1: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_idx_d   = 1'b0;
          if (bus.in_valid) begin
            trip_d  = in_trip_c;
            state_d = CALC;
          end else begin
            state_d = EMPTY;
          end
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

endmodule

// File: doc/bm_output_stage.md
BM_OUTPUT_STAGE -- requirements
Module: bm_output_stage

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `in_valid`, input, 1 bit: the upstream `f`/`g0`/`g1` triple is valid.
REQ-004 SHALL have `in_ready`, output, 1 bit: the block accepts the triple this cycle.
REQ-005 SHALL have `f`, input, 17 bits: unsigned UQ3.14 radius, sqrt(-2 ln u0), from the square-root unit.
REQ-006 SHALL have `g0`, input, 16 bits: signed Q1.15 cos(2*pi*u1).
REQ-007 SHALL have `g1`, input, 16 bits: signed Q1.15 sin(2*pi*u1).
REQ-008 SHALL have `out_valid`, output, 1 bit: a noise sample is presented.
REQ-009 SHALL have `out_ready`, input, 1 bit: downstream consumes the sample this cycle.
REQ-010 SHALL have `out_data`, output, 16 bits: signed Q4.12 Gaussian sample.
REQ-011 SHALL have `out_idx`, output, 1 bit: 0 = x0 (f*g0), 1 = x1 (f*g1).

Function
REQ-012 SHALL implement a four-state FSM: EMPTY, CALC, SEND0, SEND1.
REQ-013 EMPTY: `in_ready`=1; when `in_valid`=1, SHALL register `f`, `g0`, `g1` and go to CALC.
REQ-014 CALC: `in_ready`=0 and `out_valid`=0; SHALL compute and register x0 and x1, then go to SEND0 (exactly one cycle).
REQ-015 SEND0: `out_valid`=1, `out_idx`=0, `out_data`=x0; SHALL go to SEND1 only when `out_ready`=1, else hold.
REQ-016 SEND1: `out_valid`=1, `out_idx`=1, `out_data`=x1; `in_ready`=`out_ready`.
  - On `out_ready`=1 with `in_valid`=1: SHALL capture the new triple and go to CALC.
  - On `out_ready`=1 with `in_valid`=0: SHALL go to EMPTY.
  - On `out_ready`=0: SHALL hold.
REQ-017 Latency: a triple accepted at edge N SHALL present x0 at cycle N+2 and x1 at the first cycle after x0 is taken.
REQ-018 Throughput: peak rate SHALL be one triple per 3 cycles.
REQ-019 `out_data` and `out_idx` SHALL be stable while `out_valid`=1 and `out_ready`=0.
REQ-020 Product arithmetic:
  - Zero-extend `f` to 18 bits signed; form a 34-bit signed product with `g`, format Q4.29.
  - Reduce to 16-bit Q4.12 by arithmetic shift right by 17.
  - No saturation logic; all input combinations fit, including rounding.
REQ-021 `in_ready` SHALL be 0 in CALC and SEND0.

Reset
REQ-022 `rst`=1 SHALL force state EMPTY, `out_valid`=0, `out_data`=0, `out_idx`=0 and all registers to 0 on the next edge.
REQ-023 Reset SHALL take priority over any handshake in the same cycle.
REQ-024 A reset mid-operation SHALL discard the pending x0/x1.
REQ-025 `in_ready` SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro `AWGN_ROUND_EN` SHALL select the rounding mode:
  - Defined: add 2^16 to the product before the shift (round half up).
  - Undefined: plain truncation (floor).

Structure
REQ-027 The shared package `awgn_pkg` SHALL hold:
  - width constants F_W=17, G_W=16, OUT_W=16, PROD_W=34, SHIFT=17;
  - the FSM state enum.
REQ-028 SHALL instantiate the sub-module `bm_scale_mul` (signed 18x16 multiply plus round/shift) twice, for x0 and x1.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  1. Reset held 3 cycles, then released -> `out_valid`=0, `in_ready`=1, `out_data`=0x0000.
  2. f=0x04000, g0=0x4000, g1=0xC000, `out_ready`=1 -> 0x0800 (idx 0) at N+2, then 0xF800 (idx 1) at N+3.
  3. Scenario 2 with `out_ready`=0 for 5 cycles in SEND0 -> `out_data` held at 0x0800, `in_ready`=0 throughout.
  4. f=0x00003, g0=0x7FFF -> x0=0x0001 with `AWGN_ROUND_EN`, 0x0000 without.
  5. f=0x1FFFF, g0=0x8000, g1=0x7FFF -> x0=0x8000 in both modes; x1=0x7FFF with rounding, 0x7FFE without.
  6. Back-to-back triples with `in_valid`=1 and `out_ready`=1 -> one triple accepted every 3 cycles, outputs in order; `rst` asserted in SEND0 -> x1 never emitted, state EMPTY.
